// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Width needed to hold an occupancy count in the range 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and a registered head that holds its last value when empty.
module sync_fifo import fetch_pkg::*; #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] HEAD_INIT = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  din,
  input  logic                              pop,
  input  logic                              flush,
  output logic [WIDTH-1:0]                  head,
  output logic [count_width(DEPTH)-1:0]     count,
  output logic                              full,
  output logic                              empty
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, front_idx;
  logic [CW-1:0]    after_pop, count_nxt;
  logic [WIDTH-1:0] front_nxt;
  logic             do_push, do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && !flush && (!full || do_pop);
  assign after_pop = count - CW'(do_pop);
  assign count_nxt = flush ? '0 : after_pop + CW'(do_push);
  assign front_idx = rd_ptr + AW'(do_pop);
  // A push into an (effectively) empty queue becomes the head directly.
  assign front_nxt = (after_pop == '0) ? din : mem[front_idx];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= HEAD_INIT;
    end else begin
      count <= count_nxt;
      if (count_nxt != '0) head <= front_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= front_idx;
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, imem request, prefetch FIFO, redirect/flush, misaligned faults.
module fetch_unit import fetch_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault
);

  localparam int CW = count_width(FIFO_DEPTH);
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

  localparam fetch_entry_t HEAD_INIT = '{instr: NOP_INSTR, pc: RESET_VECTOR, fault: 1'b0};

  logic [XLEN-1:0] fetch_pc, inflight_pc;
  logic            inflight, fault_hold, fault_pend;
  logic            pop, push, full, empty, misaligned;
  logic [CW-1:0]   count;
  logic [OW-1:0]   occupancy;
  fetch_entry_t    push_entry, head;

  assign pop        = out_valid && out_ready;
  assign misaligned = (redirect_target[1:0] != 2'b00);
  // Slots that will be taken after this cycle if nothing new is issued.
  assign occupancy  = {1'b0, count} + OW'(inflight) - OW'(pop);
  assign imem_req   = rst_n && !redirect_valid && !fault_hold && (occupancy < OW'(FIFO_DEPTH));
  assign imem_addr  = fetch_pc;

  assign push = !redirect_valid && (inflight || fault_pend) && (!full || pop);

  always_comb begin
    push_entry = '{instr: imem_rdata, pc: inflight_pc, fault: 1'b0};
    if (fault_pend) push_entry = '{instr: NOP_INSTR, pc: fetch_pc, fault: 1'b1};
  end

  // fault_hold is raised with the misaligned redirect so the fault-push cycle issues nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_VECTOR;
      inflight_pc <= RESET_VECTOR;
      inflight    <= 1'b0;
      fault_hold  <= 1'b0;
      fault_pend  <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_target;
      inflight   <= 1'b0;
      fault_hold <= misaligned;
      fault_pend <= misaligned;
    end else begin
      fault_pend <= 1'b0;
      inflight   <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + XLEN'(4);
        inflight_pc <= fetch_pc;
      end
    end
  end

  sync_fifo #(
    .WIDTH     ($bits(fetch_entry_t)),
    .DEPTH     (FIFO_DEPTH),
    .HEAD_INIT (HEAD_INIT)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign out_fault = head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_fault       (out_fault)
  );

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          fault;
  } ent_t;

  // Reference: queue of buffered entries, the fetch PC, one pending memory return.
  ent_t        q[$];
  ent_t        shown;
  logic [31:0] m_pc, m_ipc;
  bit          m_infl, m_fpend, m_fhold;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_req();
    int occ;
    occ = q.size() + int'(m_infl) - int'(q.size() > 0 && out_ready);
    return !redirect_valid && !m_fhold && !m_fpend && (occ < DEPTH);
  endfunction

  task automatic model_reset();
    q.delete();
    shown   = '{instr: NOP, pc: RV, fault: 1'b0};
    m_pc    = RV;
    m_ipc   = RV;
    m_infl  = 1'b0;
    m_fpend = 1'b0;
    m_fhold = 1'b0;
  endtask

  task automatic model_update();
    bit req;
    req = m_req();
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (redirect_valid) begin
      q.delete();
      m_pc    = redirect_target;
      m_infl  = 1'b0;
      m_fhold = 1'b0;
      m_fpend = (redirect_target[1:0] != 2'b00);
    end else begin
      if (m_infl) q.push_back('{instr: mem_word(m_ipc), pc: m_ipc, fault: 1'b0});
      if (m_fpend) begin
        q.push_back('{instr: NOP, pc: m_pc, fault: 1'b1});
        m_fpend = 1'b0;
        m_fhold = 1'b1;
      end
      if (req) begin
        m_ipc  = m_pc;
        m_pc   = m_pc + 32'd4;
        m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
    if (q.size() > 0) shown = q[0];
  endtask

  task automatic check_model();
    chk("imem_req",  imem_req,  m_req());
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_pc",    out_pc,    shown.pc);
    chk("out_instr", out_instr, shown.instr);
    chk("out_fault", out_fault, shown.fault);
  endtask

  task automatic drive(input bit rv, input logic [31:0] tgt, input bit rdy);
    @(negedge clk);
    rst_n           = 1'b1;
    redirect_valid  = rv;
    redirect_target = tgt;
    out_ready       = rdy;
    imem_rdata      = m_infl ? mem_word(m_ipc) : $urandom;
    #1;
    check_model();
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
  endtask

  task automatic step(input bit rv, input logic [31:0] tgt, input bit rdy);
    drive(rv, tgt, rdy);
    commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    imem_rdata     = $urandom;
    #1;
    model_reset();
    chk("rst_req",   imem_req,  1'b0);
    chk("rst_addr",  imem_addr, RV);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_pc",    out_pc,    RV);
    chk("rst_fault", out_fault, 1'b0);
    @(posedge clk);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Startup: requests back to back, first output two cycles after first request.
    drive(1'b0, '0, 1'b1);
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h100);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("second_addr", imem_addr, 32'h104);
    chk("lat_novalid", out_valid, 1'b0);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_pc", out_pc, 32'h100);
    chk("lat_instr", out_instr, mem_word(32'h100));
    commit();
    drive(1'b0, '0, 1'b1);
    chk("tput_pc", out_pc, 32'h104);
    commit();

    // Back-pressure: two entries buffered then requests stop.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("stall_req", imem_req, 1'b0);
    chk("stall_pc", out_pc, 32'h100);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("drain0", out_pc, 32'h100);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("drain1", out_pc, 32'h104);
    commit();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Redirect while busy.
    drive(1'b1, 32'h200, 1'b0);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 32'h200);
    chk("redir_flush", out_valid, 1'b0);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("redir_gap", out_valid, 1'b0);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("redir_v", out_valid, 1'b1);
    chk("redir_pc0", out_pc, 32'h200);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("redir_pc1", out_pc, 32'h204);
    commit();

    // Misaligned target.
    drive(1'b1, 32'h202, 1'b1);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("mis_noreq", imem_req, 1'b0);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("mis_valid", out_valid, 1'b1);
    chk("mis_fault", out_fault, 1'b1);
    chk("mis_pc", out_pc, 32'h202);
    chk("mis_instr", out_instr, NOP);
    commit();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("hold_noreq", imem_req, 1'b0);
    chk("hold_empty", out_valid, 1'b0);
    commit();
    drive(1'b1, 32'h300, 1'b1);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("resume_req", imem_req, 1'b1);
    chk("resume_addr", imem_addr, 32'h300);
    commit();

    // PC wrap.
    drive(1'b1, 32'hFFFF_FFFC, 1'b1);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    commit();
    drive(1'b0, '0, 1'b1);
    chk("wrap_zero", imem_addr, 32'h0);
    commit();

    // Mid-operation reset while a return is pending.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic [31:0] tgt;
      bit          rv;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        rv = ($urandom_range(0, 11) == 0);
        r  = $urandom_range(0, 9);
        if (r < 6)      tgt = 32'h1000 + ($urandom_range(0, 255) << 2);
        else if (r < 8) tgt = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
        else            tgt = ($urandom & 32'hFFFF_FFFC) | $urandom_range(1, 3);
        step(rv, tgt, $urandom_range(0, 9) < 7);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
